// File: rtl/coeff_mem_sequencer.sv
// Coefficient memory sequencer: clear, sequential two-channel load, indexed reads; en-level handshake with
// one en=0 gap after every memory ack. Read latency 2 cycles at 1-cycle ack; coef_ready/rd_ready only in LD_WAIT/READY.
module coeff_mem_sequencer #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int CH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              coef_valid,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_ready,
  output logic              load_done,
  input  logic              rd_req,
  input  logic              rd_ch,
  input  logic [ADDR_W-2:0] rd_idx,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_clr,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_w_done,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2 * CH_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, CLR, CLR_GAP, LD_WAIT, LD_WR, LD_GAP, READY, RD, RD_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] wr_word;

  // Address/data outputs come straight from registers, so they cannot move while mem_en is high.
  assign mem_wr_addr = cnt;
  assign mem_rd_addr = rd_addr;
  assign mem_data_in = wr_word;
  assign busy        = !(state == IDLE || state == READY);

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_clr    = 1'b0;
    coef_ready = 1'b0;
    rd_ready   = 1'b0;
    case (state)
      IDLE:    if (init) state_nxt = CLR;
      CLR: begin
        mem_en  = 1'b1;
        mem_clr = 1'b1;
        if (mem_w_done) state_nxt = CLR_GAP;
      end
      CLR_GAP: state_nxt = (cnt == LAST) ? LD_WAIT : CLR;
      LD_WAIT: begin
        coef_ready = 1'b1;
        if (coef_valid) state_nxt = LD_WR;
      end
      LD_WR: begin
        mem_en = 1'b1;
        mem_wr = 1'b1;
        if (mem_w_done) state_nxt = LD_GAP;
      end
      LD_GAP:  state_nxt = (cnt == LAST) ? READY : LD_WAIT;
      READY: begin
        // init wins over a same-cycle read, so the read is not offered as accepted
        rd_ready = !init;
        if (init)        state_nxt = CLR;
        else if (rd_req) state_nxt = RD;
      end
      RD: begin
        mem_en = 1'b1;
        if (mem_data_valid) state_nxt = RD_GAP;
      end
      RD_GAP:  state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_addr   <= '0;
      wr_word   <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      rd_err   <= rd_req && (state inside {IDLE, CLR, CLR_GAP, LD_WAIT, LD_WR, LD_GAP});
      case (state)
        IDLE: if (init) begin
          cnt       <= '0;
          load_done <= 1'b0;
        end
        CLR_GAP: cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        LD_WAIT: if (coef_valid) wr_word <= coef_data;
        LD_GAP: begin
          if (cnt == LAST) load_done <= 1'b1;
          else             cnt       <= cnt + 1'b1;
        end
        READY: begin
          if (init) begin
            cnt       <= '0;
            load_done <= 1'b0;
          end else if (rd_req) begin
            rd_addr <= {rd_ch, rd_idx};
          end
        end
        RD: if (mem_data_valid) begin
          rd_data  <= mem_data_out;
          rd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_mem_sequencer.sv
// Bench for coeff_mem_sequencer: behavioural memory with random ack delay, expected-op and read-data scoreboards.
module tb_coeff_mem_sequencer;
  localparam int ADDR_W = 9, DATA_W = 16, CH_WORDS = 256, NW = 2 * CH_WORDS;

  logic clk, rst, init, coef_valid, coef_ready, load_done;
  logic [DATA_W-1:0] coef_data, rd_data, mem_data_in, mem_data_out;
  logic rd_req, rd_ch, rd_ready, rd_valid, rd_err, busy;
  logic [ADDR_W-2:0] rd_idx;
  logic mem_en, mem_wr, mem_clr, mem_w_done, mem_data_valid;
  logic [ADDR_W-1:0] mem_wr_addr, mem_rd_addr;

  coeff_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_WORDS(CH_WORDS)) dut (
    .clk(clk), .rst(rst), .init(init), .coef_valid(coef_valid), .coef_data(coef_data),
    .coef_ready(coef_ready), .load_done(load_done), .rd_req(rd_req), .rd_ch(rd_ch),
    .rd_idx(rd_idx), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_err(rd_err), .busy(busy), .mem_en(mem_en), .mem_wr(mem_wr), .mem_clr(mem_clr),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_data_in(mem_data_in),
    .mem_w_done(mem_w_done), .mem_data_valid(mem_data_valid), .mem_data_out(mem_data_out));

  typedef struct {int kind; int addr; int data;} op_t;  // kind: 0 clear, 1 write, 2 read
  op_t exp_ops[$];
  int  exp_rd[$];
  int  mirror[NW];
  int  n_checks = 0, n_fail = 0, err_seen = 0, cyc = 0, last_valid_cyc = 0;
  bit  fixed_dly = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int coef_of(input int a);
    return (a ^ 32'hA5A5) & 32'hFFFF;
  endfunction

  // Memory model + output monitor, sampled 1 time unit after each rising edge
  initial begin : mem_model
    int dly, acc_addr, cur_addr, kind;
    bit in_acc;
    op_t e;
    mem_w_done = 0; mem_data_valid = 0; mem_data_out = '0;
    in_acc = 0; dly = 0; acc_addr = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mem_w_done = 0; mem_data_valid = 0; in_acc = 0;
        continue;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rd_valid: got rd_data %0h required no read", rd_data);
        end else check("rd_data", 32'(rd_data), exp_rd.pop_front());
        last_valid_cyc = cyc;
      end
      if (rd_err) err_seen++;
      if (mem_en) check("wr_clr_exclusive", 32'(mem_wr & mem_clr), 0);
      if (mem_w_done || mem_data_valid) begin
        mem_w_done = 0; mem_data_valid = 0; in_acc = 0;
        check("en_gap_after_ack", 32'(mem_en), 0);
      end else if (mem_en) begin
        cur_addr = (mem_wr || mem_clr) ? int'(mem_wr_addr) : int'(mem_rd_addr);
        if (!in_acc) begin
          in_acc = 1; acc_addr = cur_addr;
          dly = fixed_dly ? 1 : $urandom_range(1, 3);
        end else begin
          check("addr_stable", 32'(cur_addr), 32'(acc_addr));
          dly--;
          if (dly == 0) begin
            kind = mem_clr ? 0 : (mem_wr ? 1 : 2);
            if (exp_ops.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_mem_op: got kind %0d addr %0d required none", kind, cur_addr);
            end else begin
              e = exp_ops.pop_front();
              check("op_kind", 32'(kind), 32'(e.kind));
              check("op_addr", 32'(cur_addr), 32'(e.addr));
              if (kind == 1) check("op_data", 32'(mem_data_in), 32'(e.data));
            end
            if (kind == 0) mirror[cur_addr] = 0;
            if (kind == 1) mirror[cur_addr] = int'(mem_data_in);
            if (kind == 2) begin
              mem_data_out = DATA_W'(mirror[cur_addr]);
              mem_data_valid = 1;
            end else mem_w_done = 1;
          end
        end
      end else in_acc = 0;
    end
  end

  task automatic push_clears();
    for (int i = 0; i < NW; i++) exp_ops.push_back('{0, i, 0});
  endtask

  task automatic wait_coef_ready(input int budget);
    for (int n = 0; n < budget && !coef_ready; n++) @(negedge clk);
    check("coef_ready_reached", 32'(coef_ready), 1);
  endtask

  task automatic wait_ops_empty(input int budget);
    for (int n = 0; n < budget && exp_ops.size() != 0; n++) @(negedge clk);
    check("ops_drained", 32'(exp_ops.size()), 0);
  endtask

  task automatic send_word(input int a, input bit track);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (track) exp_ops.push_back('{1, a, coef_of(a)});
    coef_valid = 1; coef_data = DATA_W'(coef_of(a));
    for (int n = 0; n < 50 && !coef_ready; n++) @(negedge clk);
    check("coef_handshake", 32'(coef_ready), 1);
    @(negedge clk);
    coef_valid = 0;
  endtask

  task automatic do_read(input bit ch, input int idx);
    for (int n = 0; n < 50 && !rd_ready; n++) @(negedge clk);
    check("rd_ready_reached", 32'(rd_ready), 1);
    exp_ops.push_back('{2, ch * CH_WORDS + idx, 0});
    exp_rd.push_back(coef_of(ch * CH_WORDS + idx));
    rd_req = 1; rd_ch = ch; rd_idx = (ADDR_W-1)'(idx);
    @(negedge clk);
    rd_req = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_coef_ready"}, 32'(coef_ready), 0);
    check({tag, "_load_done"},  32'(load_done), 0);
    check({tag, "_rd_ready"},   32'(rd_ready), 0);
    check({tag, "_rd_valid"},   32'(rd_valid), 0);
    check({tag, "_rd_err"},     32'(rd_err), 0);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_mem_ctl"},    32'({mem_en, mem_wr, mem_clr}), 0);
    check({tag, "_mem_addr"},   32'({mem_wr_addr, mem_rd_addr}), 0);
    check({tag, "_mem_din"},    32'(mem_data_in), 0);
    check({tag, "_rd_data"},    32'(rd_data), 0);
  endtask

  initial begin : stim
    int bad, acc_cyc, last_exp;
    rst = 1; init = 0; coef_valid = 0; coef_data = '0; rd_req = 0; rd_ch = 0; rd_idx = '0;
    for (int i = 0; i < NW; i++) mirror[i] = int'($urandom_range(1, 65535));
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 0;
    @(negedge clk);

    // read request before any load is rejected
    rd_req = 1; @(negedge clk); rd_req = 0; @(negedge clk);
    check("rd_err_idle", 32'(err_seen), 1);

    // clear then load the full coefficient stream
    push_clears();
    init = 1; @(negedge clk); init = 0;
    check("busy_clear", 32'(busy), 1);
    wait_coef_ready(6000);
    check("clears_done", 32'(exp_ops.size()), 0);
    bad = 0;
    for (int i = 0; i < NW; i++) if (mirror[i] != 0) bad++;
    check("mirror_cleared", 32'(bad), 0);

    for (int a = 0; a < NW; a++) begin
      if (a == 50) begin
        rd_req = 1; rd_ch = 1; rd_idx = 8'd9; @(negedge clk); rd_req = 0;
      end
      if (a == 300) check("load_done_midload", 32'(load_done), 0);
      send_word(a, 1);
    end
    for (int n = 0; n < 50 && !load_done; n++) @(negedge clk);
    check("load_done_set", 32'(load_done), 1);
    check("load_ops_drained", 32'(exp_ops.size()), 0);
    check("rd_err_during_load", 32'(err_seen), 2);
    check("no_read_on_err", 32'(exp_rd.size()), 0);
    bad = 0;
    for (int i = 0; i < NW; i++) if (mirror[i] != coef_of(i)) bad++;
    check("mirror_loaded", 32'(bad), 0);

    // directed read ch1 idx3 with a 1-cycle memory ack
    fixed_dly = 1;
    do_read(1, 3);
    acc_cyc = cyc;
    check("rd_addr_259", 32'(mem_rd_addr), 259);
    for (int n = 0; n < 20 && exp_rd.size() != 0; n++) @(negedge clk);
    check("rd_drained", 32'(exp_rd.size()), 0);
    check("rd_latency", 32'(last_valid_cyc - acc_cyc), 2);
    fixed_dly = 0;

    // random reads
    last_exp = 0;
    for (int k = 0; k < 12; k++) begin
      bit ch;
      int idx;
      ch = 1'($urandom_range(0, 1)); idx = int'($urandom_range(0, CH_WORDS - 1));
      last_exp = coef_of(ch * CH_WORDS + idx);
      do_read(ch, idx);
    end
    for (int n = 0; n < 50 && exp_rd.size() != 0; n++) @(negedge clk);
    check("rand_rd_drained", 32'(exp_rd.size()), 0);
    repeat (5) @(negedge clk);
    check("rd_data_hold", 32'(rd_data), 32'(last_exp));

    // init and rd_req in the same READY cycle: init wins
    push_clears();
    init = 1; rd_req = 1; rd_ch = 0; rd_idx = 8'd7;
    @(negedge clk);
    init = 0; rd_req = 0;
    check("init_prio_busy", 32'(busy), 1);
    check("init_prio_load_done", 32'(load_done), 0);
    check("init_prio_clr", 32'({mem_en, mem_clr, mem_wr}), 32'b110);
    check("init_prio_addr", 32'(mem_wr_addr), 0);
    wait_coef_ready(6000);
    check("reclear_done", 32'(exp_ops.size()), 0);
    check("no_err_in_ready", 32'(err_seen), 2);
    check("no_read_on_init", 32'(exp_rd.size()), 0);

    // reset in the middle of writing address 100
    for (int a = 0; a < 100; a++) send_word(a, 1);
    send_word(100, 0);
    check("ldwr_en", 32'({mem_en, mem_wr}), 32'b11);
    check("ldwr_addr", 32'(mem_wr_addr), 100);
    check("ldwr_data", 32'(mem_data_in), 32'(coef_of(100)));
    wait_ops_empty(20);
    rst = 1;
    #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst = 0;
    exp_ops.delete();
    @(negedge clk);
    push_clears();
    init = 1; @(negedge clk); init = 0;
    wait_coef_ready(6000);
    check("rst_reclear_done", 32'(exp_ops.size()), 0);
    for (int a = 0; a < 4; a++) send_word(a, 1);
    wait_ops_empty(20);
    bad = 0;
    for (int i = 0; i < 4; i++) if (mirror[i] != coef_of(i)) bad++;
    check("reload_from_0", 32'(bad), 0);
    check("reload_not_done", 32'(load_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
